// File: rtl/pipe_pkg.sv
// +-------------------------------------------------------------------------+
// | pipe_pkg : shared types for the generic handshake pipeline stage         |
// | Rev 1.0  : initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_payload_t;

  localparam int ID_EX_W = $bits(id_ex_payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// +-------------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones instead of wrapping     |
// | Rev 1.0     : initial release                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_stage_hs.sv
// +-------------------------------------------------------------------------+
// | pipe_stage_hs : flushable valid/ready stage register, opaque payload     |
// | Build option  : PIPE_SKID_EN selects the 2-entry skid buffer variant     |
// | Rev 1.0       : initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = ID_EX_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] data_q;

`ifdef PIPE_SKID_EN
  skid_state_e          state_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 rdy_q;
  logic                 accept;
  logic                 emit;

  // rdy_q is a flop; reset_n only forces it low while reset is asserted.
  assign in_ready = rdy_q & reset_n;
  assign accept   = in_valid & rdy_q;
  assign emit     = valid_q & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      data_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else if (flush_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      data_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            data_q  <= in_data;
            valid_q <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            skid_q  <= in_data;
            rdy_q   <= 1'b0;
            state_q <= TWO;
          end else if (accept && emit) begin
            data_q  <= in_data;
          end else if (emit) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            data_q  <= skid_q;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          data_q  <= '0;
          skid_q  <= '0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end
`else
  logic                 valid_d;
  logic [PAYLOAD_W-1:0] data_d;
  logic                 accept;
  logic                 emit;

  assign in_ready = reset_n & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign emit     = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (emit) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Skid can only be occupied while main is valid, so valid_q covers both.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (valid_q & ~out_ready & ~flush_i),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (flush_i & valid_q),
    .cnt_o   (flush_cnt)
  );

endmodule : pipe_stage_hs

`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs (CNT_W=3), both with and without PIPE_SKID_EN.
`default_nettype none

module tb_pipe_stage_hs;

  localparam int PW = 175;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush_i;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [PW-1:0] q[$];
  logic          exp_rdy;

  initial begin
    reset_n   = 1'b0;
    flush_i   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);

    // 1: async reset in the middle of a cycle with a beat held
    in_valid = 1'b1; in_data = 'hAB;
    tick();
    chk("pre_reset_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 2: streaming 8 beats
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = PW'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_end_data", out_data, 0);

    // 3: backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 'h11;
    tick();
    in_data = 'h22;
    #1;
`ifdef PIPE_SKID_EN
    chk("bp_first_ready", in_ready, 1);
`else
    chk("bp_first_ready", in_ready, 0);
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
`ifdef PIPE_SKID_EN
      in_valid = 1'b0;
`endif
      chk("bp_hold_data", out_data, 'h11);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_stall_cnt", stall_cnt, 5);
    out_ready = 1'b1;
    #1;
    chk("bp_release_data", out_data, 'h11);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", out_data, 'h22);
    tick();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_stall_after", stall_cnt, 5);

    // 4: flush with a held beat and an incoming beat
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 'h44;
    tick();
    flush_i = 1'b1; in_data = 'h33;
    tick();
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 0);
    chk("flush_data", out_data, 0);
    chk("flush_cnt_1", flush_cnt, 1);
    chk("flush_no_stall", stall_cnt, 5);
    tick();
    chk("flush_33_dropped", out_valid, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_empty_cnt", flush_cnt, 1);

    // 5: stall counter saturation
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 'h55;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("sat_reach", stall_cnt, 7);
    for (int k = 0; k < 8; k++) tick();
    chk("sat_hold", stall_cnt, 7);
    out_ready = 1'b1;
    tick();
    chk("sat_drain", out_valid, 0);

    // 6: random valid/ready/flush against a FIFO reference
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 39) == 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      #1;
`ifdef PIPE_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || out_ready;
`endif
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, exp_rdy);
      if (flush_i) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          chk("rnd_data", out_data, q[0]);
          void'(q.pop_front());
        end
        if (in_valid && exp_rdy) q.push_back(in_data);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_stage_hs

`default_nettype wire
